// File: rtl/multibit_cdc_req_resp_bridge.sv
// Single-outstanding aclk->bclk request / bclk->aclk response bridge using toggle flags and held payloads; MULTIBIT_CDC_TIMEOUT_EN adds an A-side timeout with late-response drain.
// Latency SYNC_STAGES+1 receiving-clock edges each way; a_req_ready stays low until the round trip completes, and both sides hold valid until accepted.
module multibit_cdc_req_resp_bridge #(
    parameter int REQ_WIDTH      = 32,
    parameter int RSP_WIDTH      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 bclk,
    input  logic                 breset,
    input  logic                 a_req_valid,
    input  logic [REQ_WIDTH-1:0] a_req_data,
    output logic                 a_req_ready,
    output logic                 a_rsp_valid,
    output logic [RSP_WIDTH-1:0] a_rsp_data,
    output logic                 a_rsp_err,
    input  logic                 a_rsp_ready,
    output logic                 b_req_valid,
    output logic [REQ_WIDTH-1:0] b_req_data,
    input  logic                 b_req_ready,
    input  logic                 b_rsp_valid,
    input  logic [RSP_WIDTH-1:0] b_rsp_data,
    output logic                 b_rsp_ready
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("multibit_cdc_req_resp_bridge: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
    end

`ifdef MULTIBIT_CDC_TIMEOUT_EN
    typedef enum logic [1:0] {A_IDLE, A_WAIT, A_RSP, A_DRAIN} a_state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          a_err_q, a_err_d;
`else
    typedef enum logic [1:0] {A_IDLE, A_WAIT, A_RSP} a_state_t;
`endif
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} b_state_t;

    a_state_t               a_state_q, a_state_d;
    logic                   req_tog_q, req_tog_d;
    logic [REQ_WIDTH-1:0]   req_hold_q, req_hold_d;
    logic [RSP_WIDTH-1:0]   a_rsp_data_q, a_rsp_data_d;
    logic [SYNC_STAGES-1:0] rsp_sync_q, rsp_sync_d;
    logic                   rsp_done;

    b_state_t               b_state_q, b_state_d;
    logic                   b_seen_q, b_seen_d;
    logic                   rsp_tog_q, rsp_tog_d;
    logic [RSP_WIDTH-1:0]   rsp_hold_q, rsp_hold_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   req_synced;

    // Parity match means the responder has answered the latest request.
    assign rsp_sync_d = {rsp_sync_q[SYNC_STAGES-2:0], rsp_tog_q};
    assign rsp_done   = (rsp_sync_q[SYNC_STAGES-1] == req_tog_q);

    always_comb begin
        a_state_d    = a_state_q;
        req_tog_d    = req_tog_q;
        req_hold_d   = req_hold_q;
        a_rsp_data_d = a_rsp_data_q;
`ifdef MULTIBIT_CDC_TIMEOUT_EN
        timer_d      = timer_q;
        a_err_d      = a_err_q;
`endif
        case (a_state_q)
            A_IDLE: begin
                if (a_req_valid) begin
                    req_hold_d = a_req_data;
                    req_tog_d  = ~req_tog_q;
                    a_state_d  = A_WAIT;
`ifdef MULTIBIT_CDC_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end
            end
            A_WAIT: begin
                if (rsp_done) begin
                    a_rsp_data_d = rsp_hold_q;
                    a_state_d    = A_RSP;
                end
`ifdef MULTIBIT_CDC_TIMEOUT_EN
                else if (timer_q == TMO_LAST) begin
                    a_rsp_data_d = '0;
                    a_err_d      = 1'b1;
                    a_state_d    = A_RSP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            A_RSP: begin
                if (a_rsp_ready) begin
`ifdef MULTIBIT_CDC_TIMEOUT_EN
                    a_state_d = a_err_q ? A_DRAIN : A_IDLE;
                    a_err_d   = 1'b0;
`else
                    a_state_d = A_IDLE;
`endif
                end
            end
`ifdef MULTIBIT_CDC_TIMEOUT_EN
            // The abandoned response still toggles rsp_tog; wait it out so parity realigns.
            A_DRAIN: begin
                if (rsp_done) a_state_d = A_IDLE;
            end
`endif
            default: a_state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            a_state_q    <= A_IDLE;
            req_tog_q    <= 1'b0;
            req_hold_q   <= '0;
            a_rsp_data_q <= '0;
            rsp_sync_q   <= '0;
`ifdef MULTIBIT_CDC_TIMEOUT_EN
            timer_q      <= '0;
            a_err_q      <= 1'b0;
`endif
        end else begin
            a_state_q    <= a_state_d;
            req_tog_q    <= req_tog_d;
            req_hold_q   <= req_hold_d;
            a_rsp_data_q <= a_rsp_data_d;
            rsp_sync_q   <= rsp_sync_d;
`ifdef MULTIBIT_CDC_TIMEOUT_EN
            timer_q      <= timer_d;
            a_err_q      <= a_err_d;
`endif
        end
    end

    assign a_req_ready = (a_state_q == A_IDLE);
    assign a_rsp_valid = (a_state_q == A_RSP);
    assign a_rsp_data  = a_rsp_data_q;
`ifdef MULTIBIT_CDC_TIMEOUT_EN
    assign a_rsp_err   = a_err_q;
`else
    assign a_rsp_err   = 1'b0;
`endif

    assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_tog_q};
    assign req_synced = req_sync_q[SYNC_STAGES-1];

    always_comb begin
        b_state_d  = b_state_q;
        b_seen_d   = b_seen_q;
        rsp_tog_d  = rsp_tog_q;
        rsp_hold_d = rsp_hold_q;
        case (b_state_q)
            B_IDLE: begin
                if (req_synced != b_seen_q) b_state_d = B_REQ;
            end
            B_REQ: begin
                if (b_req_ready) begin
                    b_seen_d  = req_synced;
                    b_state_d = B_WAIT;
                end
            end
            B_WAIT: begin
                if (b_rsp_valid) begin
                    rsp_hold_d = b_rsp_data;
                    rsp_tog_d  = ~rsp_tog_q;
                    b_state_d  = B_IDLE;
                end
            end
            default: b_state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (breset) begin
            b_state_q  <= B_IDLE;
            b_seen_q   <= 1'b0;
            rsp_tog_q  <= 1'b0;
            rsp_hold_q <= '0;
            req_sync_q <= '0;
        end else begin
            b_state_q  <= b_state_d;
            b_seen_q   <= b_seen_d;
            rsp_tog_q  <= rsp_tog_d;
            rsp_hold_q <= rsp_hold_d;
            req_sync_q <= req_sync_d;
        end
    end

    // req_hold is frozen from accept until the response returns, so bclk reads it safely.
    assign b_req_valid = (b_state_q == B_REQ);
    assign b_req_data  = req_hold_q;
    assign b_rsp_ready = (b_state_q == B_WAIT);

endmodule

// File: doc/multibit_cdc_req_resp_bridge.md
Name: multibit_cdc_req_resp_bridge

Overview:
- Single-outstanding request/response bridge between two asynchronous clock domains.
- Initiator side (aclk) issues a request word, which crosses to the responder side (bclk). The responder's answer word crosses back to aclk.
- Uses toggle flags plus double-flop synchronizers and held data registers, so no multi-bit bus is ever sampled while changing.
- Sits between an aclk master and a bclk slave. It is the round-trip complement of the one-way valid/ready synchronizer.

Parameters:
- REQ_WIDTH, 32, request data width.
- RSP_WIDTH, 32, response data width.
- SYNC_STAGES, 2, flops per toggle synchronizer; legal values are 2 or more.
- TIMEOUT_CYCLES, 1024, aclk cycles before timeout. Used only with the optional feature.

Ports:
- aclk  in  1  initiator clock; reset areset, synchronous, active-high; clock aclk
- areset  in  1  initiator reset, synchronous, active-high
- bclk  in  1  responder clock
- breset  in  1  responder reset, synchronous, active-high
- a_req_valid  in  1  request offered
- a_req_data  in  REQ_WIDTH  request payload
- a_req_ready  out  1  bridge can accept a request
- a_rsp_valid  out  1  response available
- a_rsp_data  out  RSP_WIDTH  response payload
- a_rsp_err  out  1  response is a timeout error
- a_rsp_ready  in  1  initiator consumes the response
- b_req_valid  out  1  request presented to the responder
- b_req_data  out  REQ_WIDTH  request payload
- b_req_ready  in  1  responder accepts the request
- b_rsp_valid  in  1  responder offers a response
- b_rsp_data  in  RSP_WIDTH  response payload
- b_rsp_ready  out  1  bridge accepts the response

Behaviour:
- Reset:
  - areset clears A_IDLE, req_tog, the aclk synchronizer flops, req_hold and the A timer. After reset, a_req_ready=1, a_rsp_valid=0, a_rsp_err=0.
  - breset clears B_IDLE, b_seen, rsp_tog, the bclk synchronizer flops and rsp_hold. After reset, b_req_valid=0, b_rsp_ready=0.
  - Both resets must overlap; a one-sided reset mid-transaction is unsupported and the bench must not do it.
- A-side FSM, states A_IDLE, A_WAIT, A_RSP (plus A_DRAIN, optional):
  - A_IDLE: a_req_ready=1. On a_req_valid&a_req_ready: req_hold<=a_req_data, req_tog toggles, go to A_WAIT.
  - A_WAIT: a_req_ready=0. When rsp_tog synchronized into aclk equals req_tog: a_rsp_data<=rsp_hold, go to A_RSP.
  - A_RSP: a_rsp_valid=1 and a_rsp_data is held. On a_rsp_valid&a_rsp_ready, go to A_IDLE. A new request is accepted no earlier than the following cycle.
- B-side FSM, states B_IDLE, B_REQ, B_WAIT:
  - B_IDLE: when req_tog synchronized into bclk differs from b_seen, go to B_REQ.
  - B_REQ: b_req_valid=1, b_req_data=req_hold. On b_req_valid&b_req_ready: b_seen<=synchronized req_tog, go to B_WAIT.
  - B_WAIT: b_rsp_ready=1. On b_rsp_valid: rsp_hold<=b_rsp_data, rsp_tog toggles, go to B_IDLE.
- Data rules: req_hold changes only in A_IDLE on accept. rsp_hold changes only in B_WAIT on accept. Both are stable whenever the opposite domain samples them.
- Latency: b_req_valid rises SYNC_STAGES+1 bclk edges after the A accept, ±1 edge of phase uncertainty. a_rsp_valid rises SYNC_STAGES+1 aclk edges after the B response accept, with the same ±1.
- Toggle parity guarantees each transaction is seen exactly once. Back-to-back transactions are legal and each is a full round trip.
- Boundary conditions:
  - a_req_valid held high while in A_WAIT or A_RSP is ignored.
  - b_rsp_valid outside B_WAIT is ignored.
  - Payload width mismatch is not applicable: each direction has its own width parameter.

Optional Feature:
- Macro MULTIBIT_CDC_TIMEOUT_EN.
- Defined:
  - An A-side counter starts at 0 on entry to A_WAIT.
  - If it reaches TIMEOUT_CYCLES-1 with no response, go to A_RSP with a_rsp_err=1 and a_rsp_data=0.
  - After that response is consumed, go to A_DRAIN. A_DRAIN holds a_req_ready=0 until the synchronized rsp_tog equals req_tog, discards the late response, then goes to A_IDLE.
  - A response arriving on the exact timeout cycle takes priority: err=0, normal A_RSP.
- Undefined:
  - No counter and no A_DRAIN state; A_WAIT waits indefinitely.
  - a_rsp_err is tied to 0.

Test Plan:
- Reset both domains, aclk 100 MHz, bclk 37 MHz; send req 0xDEADBEEF; responder answers 0x12345678 -> b_req_data=0xDEADBEEF seen once; a_rsp_data=0x12345678, a_rsp_err=0; a_req_ready=0 throughout the round trip.
- 100 back-to-back random requests, responder echoes req+1 -> 100 responses, each equal to its request+1, in order, no duplicates or drops.
- Hold a_req_valid=1 continuously and hold a_rsp_ready=0 for 20 cycles -> a_rsp_valid and a_rsp_data stable for all 20 cycles; no second request enters the B side.
- Responder stalls b_req_ready=0 for 50 bclk cycles -> b_req_valid and b_req_data held constant; transaction completes normally afterwards.
- Swap clock ratio to aclk 25 MHz, bclk 200 MHz -> same results; latency within SYNC_STAGES+2 cycles of the receiving clock.
- With the macro, TIMEOUT_CYCLES=16, responder silent for 200 bclk cycles then answers 0xAA -> a_rsp_err=1 with data 0 after 16 aclk cycles; a_req_ready stays 0 until the late 0xAA is drained; the next request then completes with err=0.
